// File: rtl/sipo_rx_pkg.sv
// Shared definitions for the serial frame receiver: state encoding, line idle level
// and the counter-width helper.
package sipo_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_e;

  localparam logic SERIAL_IDLE = 1'b1;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/sipo_shift_reg.sv
// Serial-in/parallel-out shift register; new bits enter at the MSB so the first
// bit received ends up in bit 0 once the word is complete.
module sipo_shift_reg #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              shift_en,
  input  logic              serial_in,
  output logic [DATA_W-1:0] parallel_out
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parallel_out <= '0;
    end else if (shift_en) begin
      parallel_out <= {serial_in, parallel_out[DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/sipo_rx_controller.sv
// Serial frame receiver: start-bit detection, data/parity/stop sequencing on the
// bit-rate strobe, and a single-entry valid/ready output register.
module sipo_rx_controller #(
  parameter int DATA_W     = 4,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bit_en,
  input  logic              serial_in,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun
);
  import sipo_rx_pkg::*;

  localparam int              CNT_W      = clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_W - 1);
  localparam logic            PAR_INIT   = (PARITY_ODD != 0);
  localparam logic            USE_PARITY = (PARITY_EN != 0);

  rx_state_e         state, state_next;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_next;
  logic              par_acc, par_next;
  logic              shift_en;
  logic [DATA_W-1:0] shift_word;
  logic              deliver;
  logic              parity_err_next, frame_err_next, overrun_next;
  logic              reg_free;

  sipo_shift_reg #(.DATA_W(DATA_W)) u_shift (
    .clk          (clk),
    .reset        (reset),
    .shift_en     (shift_en),
    .serial_in    (serial_in),
    .parallel_out (shift_word)
  );

  // A word being accepted this very cycle frees the register for a new delivery.
  assign reg_free = !out_valid || out_ready;
  assign busy     = (state != IDLE);

  always_comb begin
    state_next      = state;
    bit_cnt_next    = bit_cnt;
    par_next        = par_acc;
    shift_en        = 1'b0;
    deliver         = 1'b0;
    parity_err_next = 1'b0;
    frame_err_next  = 1'b0;
    overrun_next    = 1'b0;
    if (bit_en) begin
      case (state)
        IDLE: begin
          if (serial_in != SERIAL_IDLE) begin
            state_next   = DATA;
            bit_cnt_next = '0;
            par_next     = PAR_INIT;
          end
        end
        DATA: begin
          shift_en     = 1'b1;
          par_next     = par_acc ^ serial_in;
          bit_cnt_next = bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) state_next = USE_PARITY ? PARITY : STOP;
        end
        PARITY: begin
          par_next   = par_acc ^ serial_in;
          state_next = STOP;
        end
        STOP: begin
          state_next = IDLE;
          // Only the highest-priority outcome is reported for a frame.
          if (serial_in != SERIAL_IDLE)    frame_err_next  = 1'b1;
          else if (USE_PARITY && par_acc)  parity_err_next = 1'b1;
          else if (reg_free)               deliver         = 1'b1;
          else                             overrun_next    = 1'b1;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      par_acc <= 1'b0;
    end else begin
      state   <= state_next;
      bit_cnt <= bit_cnt_next;
      par_acc <= par_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (deliver) begin
        out_data  <= shift_word;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      parity_err <= parity_err_next;
      frame_err  <= frame_err_next;
      overrun    <= overrun_next;
    end
  end

endmodule
